// File: rtl/aes_wb_master.sv
// Wishbone classic master that runs one AES-192 job: it writes the operands, pulses start, polls
// status and reads back the ciphertext. Define AES_WB_POLL_TIMEOUT_EN to bound the poll loop.
module aes_wb_master #(
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000,
  parameter int unsigned POLL_LIMIT = 1024
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic         req_valid_i,
  output logic         req_ready_o,
  input  logic [127:0] req_pt_i,
  input  logic [191:0] req_key_i,
  output logic         rsp_valid_o,
  input  logic         rsp_ready_i,
  output logic [127:0] rsp_ct_o,
  output logic         rsp_err_o,
  output logic         busy_o,
  output logic [31:0]  wb_adr_o,
  output logic [31:0]  wb_dat_o,
  output logic [3:0]   wb_sel_o,
  output logic         wb_we_o,
  output logic         wb_cyc_o,
  output logic         wb_stb_o,
  input  logic [31:0]  wb_dat_i,
  input  logic         wb_ack_i,
  input  logic         wb_err_i
);

  typedef enum logic [2:0] {StIdle, StWrite, StStartHi, StStartLo, StPoll, StRead, StResp} state_e;

  state_e       state_q, state_d;
  logic         gap_q, gap_d;   // idle cycle after each completed access
  logic [3:0]   word_q, word_d;
  logic         err_q, err_d;
  logic [127:0] pt_q, ct_q;
  logic [191:0] key_q;
  logic         accept, strobe, done, poll_timeout;
  logic [319:0] payload;
  logic [8:0]   wr_sel;
  logic [31:0]  wr_word;

  assign accept  = (state_q == StIdle) & req_valid_i;
  assign strobe  = (state_q inside {StWrite, StStartHi, StStartLo, StPoll, StRead}) & ~gap_q;
  assign done    = strobe & (wb_ack_i | wb_err_i);
  assign payload = {key_q, pt_q};
  assign wr_sel  = {word_q - 4'd1, 5'd0};

  always_comb begin
    wr_word = '0;
    if (word_q >= 4'd1 && word_q <= 4'd10) wr_word = payload[wr_sel +: 32];
  end

`ifdef AES_WB_POLL_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(POLL_LIMIT + 1);
  logic [CntW-1:0] poll_cnt_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      poll_cnt_q <= '0;
    end else if (state_q == StStartLo && done) begin
      poll_cnt_q <= '0;
    end else if (state_q == StPoll && done && !wb_err_i && !wb_dat_i[0]) begin
      poll_cnt_q <= poll_cnt_q + 1'b1;
    end
  end

  // True while the read in flight would be the POLL_LIMIT-th not-ready status
  assign poll_timeout = (poll_cnt_q == CntW'(POLL_LIMIT - 1));
`else
  assign poll_timeout = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= StIdle;
      gap_q   <= 1'b0;
      word_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      gap_q   <= gap_d;
      word_q  <= word_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      pt_q  <= '0;
      key_q <= '0;
      ct_q  <= '0;
    end else if (accept) begin
      pt_q  <= req_pt_i;
      key_q <= req_key_i;
      ct_q  <= '0;
    end else if (done && wb_err_i) begin
      ct_q  <= '0;
    end else if (done && state_q == StRead) begin
      ct_q  <= {ct_q[95:0], wb_dat_i};
    end
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    word_d  = word_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          state_d = StWrite;
          word_d  = 4'd1;
          gap_d   = 1'b0;
          err_d   = 1'b0;
        end
      end
      StResp: begin
        if (gap_q) gap_d = 1'b0;
        else if (rsp_ready_i) state_d = StIdle;
      end
      default: begin
        if (gap_q) begin
          gap_d = 1'b0;
        end else if (wb_err_i) begin
          state_d = StResp;
          gap_d   = 1'b1;
          err_d   = 1'b1;
        end else if (wb_ack_i) begin
          gap_d = 1'b1;
          case (state_q)
            StWrite: begin
              if (word_q == 4'd10) begin
                state_d = StStartHi;
                word_d  = 4'd0;
              end else begin
                word_d  = word_q + 4'd1;
              end
            end
            StStartHi: state_d = StStartLo;
            StStartLo: begin
              state_d = StPoll;
              word_d  = 4'd11;
            end
            StPoll: begin
              if (wb_dat_i[0]) begin
                state_d = StRead;
                word_d  = 4'd12;
              end else if (poll_timeout) begin
                state_d = StResp;
                err_d   = 1'b1;
              end
            end
            StRead: begin
              if (word_q == 4'd15) state_d = StResp;
              else word_d = word_q + 4'd1;
            end
            default: state_d = StIdle;
          endcase
        end
      end
    endcase
  end

  always_comb begin
    req_ready_o = (state_q == StIdle);
    busy_o      = (state_q != StIdle);
    rsp_valid_o = (state_q == StResp) & ~gap_q;
    rsp_err_o   = rsp_valid_o & err_q;
    rsp_ct_o    = rsp_valid_o ? ct_q : '0;
    wb_cyc_o    = strobe;
    wb_stb_o    = strobe;
    wb_sel_o    = 4'hF;
    wb_we_o     = strobe & (state_q inside {StWrite, StStartHi, StStartLo});
    wb_adr_o    = strobe ? BASE_ADDR + {26'd0, word_q, 2'b00} : '0;
    wb_dat_o    = '0;
    if (wb_we_o) begin
      if (state_q == StWrite) wb_dat_o = wr_word;
      else if (state_q == StStartHi) wb_dat_o = 32'h1;
    end
  end

endmodule
